uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte sources, e.g. requester 0 = CPU MMIO TX register, requester 1 = RX echo path.
- Accepts one byte per handshake, issues a one-cycle tx_start to the UART, then tracks tx_busy until the byte has left.
- Sits between the requesters and the uart instance in top-level glue. Prevents lost bytes when two sources collide.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources; round robin by default,
// fixed lowest-index priority when UART_ARB_PRIORITY_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 arb_busy,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          any_valid;
  logic [2:0]    lo_idx;
  logic [2:0]    winner;
  logic [7:0]    sel_data;
  logic          accept;

  // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i] in the
  // same cycle; requesters hold req_data stable while valid, ready never waits on data.
  always_comb begin
    any_valid = 1'b0;
    lo_idx    = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        lo_idx    = 3'(i);
      end
    end
  end

`ifdef UART_ARB_PRIORITY_EN
  assign winner = lo_idx;
`else
  logic [2:0] ptr;
  logic       hi_found;
  logic [2:0] hi_idx;

  // First valid index above the pointer; otherwise the lowest valid one (wrap-around).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (3'(i) > ptr)) begin
        hi_found = 1'b1;
        hi_idx   = 3'(i);
      end
    end
  end

  assign winner = hi_found ? hi_idx : lo_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= 3'(NUM_REQ - 1);
    end else if (accept) begin
      ptr <= winner;
    end
  end
`endif

  always_comb begin
    sel_data = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == winner) sel_data = req_data[8*i +: 8];
    end
  end

  assign accept = (state == IDLE) && any_valid && !tx_busy;

  always_comb begin
    req_ready = '0;
    if (accept && resetn) req_ready = NUM_REQ'(1) << winner;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) state_nxt = WAIT_DONE;
        else if (cnt + CW'(1) == CW'(BUSY_TIMEOUT)) state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_data  <= 8'd0;
      grant_id <= 3'd0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= winner;
      end
      if (state == START) cnt <= '0;
      else if (state == WAIT_BUSY && !tx_busy) cnt <= cnt + CW'(1);
    end
  end

  assign tx_start  = (state == START);
  assign arb_busy  = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester instance with a UART busy model
// and a 3-requester instance (tx_busy tied low) for pointer wrap-around.
module tb_uart_tx_arbiter;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // 2-requester DUT
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  wire  [1:0]  req_ready;
  wire  [7:0]  tx_data;
  wire         tx_start;
  wire         tx_busy;
  wire  [2:0]  grant_id;
  wire         arb_busy;
  wire  [1:0]  state_dbg;

  // 3-requester DUT
  logic [2:0]  r3_valid;
  logic [23:0] r3_data;
  wire  [2:0]  r3_ready;
  wire  [7:0]  r3_txd;
  wire         r3_start;
  wire         r3_busy_in;
  wire  [2:0]  r3_gid;
  wire         r3_abusy;
  wire  [1:0]  r3_state;

  assign r3_busy_in = 1'b0;

  // UART model: busy for 10 cycles starting the cycle after tx_start
  logic uart_en, force_busy;
  int   busy_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) busy_cnt <= 0;
    else if (tx_start && uart_en) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0) || force_busy;

  uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .state_dbg(state_dbg)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .BUSY_TIMEOUT(4)) dut3 (
    .clk(clk), .resetn(resetn), .req_valid(r3_valid), .req_data(r3_data),
    .req_ready(r3_ready), .tx_data(r3_txd), .tx_start(r3_start), .tx_busy(r3_busy_in),
    .grant_id(r3_gid), .arb_busy(r3_abusy), .state_dbg(r3_state)
  );

  // scoreboard
  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    step();
    while (!tx_start && n < 60) begin
      step();
      n++;
    end
    check({tag, "_start"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (arb_busy && n < 60) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    int busy_cycles, starts, n;
    logic [7:0] exp_b;
    logic [2:0] exp_g;

    resetn = 1'b1; uart_en = 1'b1; force_busy = 1'b0;
    req_valid = 2'b11; req_data = 16'h0;
    r3_valid = 3'b101; r3_data = 24'h0;
    #2 resetn = 1'b0;

    // reset state, with requests pending
    repeat (2) step();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_r3_ready", 32'(r3_ready), 32'd0);
    req_valid = 2'b00; r3_valid = 3'b000;
    resetn = 1'b1;

    // contention: both requesters valid for 8 bytes
    step();
    req_data = {8'h20, 8'h10};
    req_valid = 2'b11;
`ifdef UART_ARB_PRIORITY_EN
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h10);
`else
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 8'h10 : 8'h20);
`endif
    #1 check("cont_ready0", 32'(req_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_start("cont");
      exp_b = exp_q.pop_front();
      exp_g = (exp_b == 8'h20) ? 3'd1 : 3'd0;
      check("cont_data", 32'(tx_data), 32'(exp_b));
      check("cont_grant", 32'(grant_id), 32'(exp_g));
      if (k == 7) req_valid = 2'b00;
    end
    step();
    wait_idle("cont");

    // single byte with 10-cycle UART busy
    step();
    req_data[7:0] = 8'h41;
    req_valid = 2'b01;
    #1 check("sb_ready", 32'(req_ready), 32'd1);
    step();
    check("sb_start", 32'(tx_start), 32'd1);
    check("sb_data", 32'(tx_data), 32'h41);
    check("sb_grant", 32'(grant_id), 32'd0);
    req_valid = 2'b00;
    req_data[7:0] = 8'hFF;
    busy_cycles = 1; starts = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!arb_busy) break;
      busy_cycles++;
      if (tx_start) starts++;
    end
    check("sb_busy_cycles", 32'(busy_cycles), 32'd12);
    check("sb_one_start", 32'(starts), 32'd1);
    check("sb_data_held", 32'(tx_data), 32'h41);
    check("sb_idle_state", 32'(state_dbg), 32'd0);

    // timeout: UART never raises busy
    uart_en = 1'b0;
    step();
    req_data[15:8] = 8'h55;
    req_valid = 2'b10;
    #1 check("to_ready", 32'(req_ready), 32'd2);
    step();
    check("to_start", 32'(tx_start), 32'd1);
    check("to_data", 32'(tx_data), 32'h55);
    req_valid = 2'b00;
    step();
    check("to_wait_busy", 32'(state_dbg), 32'd2);
    repeat (3) step();
    check("to_busy_w3", 32'(arb_busy), 32'd1);
    step();
    check("to_idle_w4", 32'(arb_busy), 32'd0);
    req_data[7:0] = 8'h66;
    req_valid = 2'b01;
    #1 check("to_next_ready", 32'(req_ready), 32'd1);
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        check("to_next_data", 32'(tx_data), 32'h66);
        req_valid = 2'b00;
      end
      if (tx_start) starts++;
    end
    check("to_one_start", 32'(starts), 32'd1);
    check("to_final_idle", 32'(arb_busy), 32'd0);
    uart_en = 1'b1;

    // foreign busy holds off acceptance
    step();
    force_busy = 1'b1;
    req_data[15:8] = 8'h77;
    req_valid = 2'b10;
    #1 check("fb_ready_blocked", 32'(req_ready), 32'd0);
    step();
    check("fb_still_blocked", 32'(req_ready), 32'd0);
    check("fb_idle", 32'(arb_busy), 32'd0);
    step();
    force_busy = 1'b0;
    #1 check("fb_ready_on_fall", 32'(req_ready), 32'd2);
    step();
    check("fb_start", 32'(tx_start), 32'd1);
    check("fb_data", 32'(tx_data), 32'h77);
    check("fb_grant", 32'(grant_id), 32'd1);
    req_valid = 2'b00;
    step();
    wait_idle("fb");

    // reset in WAIT_DONE
    step();
    req_data[15:8] = 8'h99;
    req_valid = 2'b10;
    step();
    check("rm_start", 32'(tx_start), 32'd1);
    req_valid = 2'b00;
    step();
    step();
    check("rm_wait_done", 32'(state_dbg), 32'd3);
    check("rm_grant_before", 32'(grant_id), 32'd1);
    req_data[7:0] = 8'h5A;
    req_valid = 2'b11;
    #1 resetn = 1'b0;
    #1;
    check("rm_tx_start", 32'(tx_start), 32'd0);
    check("rm_tx_data", 32'(tx_data), 32'd0);
    check("rm_grant", 32'(grant_id), 32'd0);
    check("rm_arb_busy", 32'(arb_busy), 32'd0);
    check("rm_req_ready", 32'(req_ready), 32'd0);
    step();
    resetn = 1'b1;
    #1 check("rm_req0_wins", 32'(req_ready), 32'd1);
    step();
    check("rm_start2", 32'(tx_start), 32'd1);
    check("rm_data2", 32'(tx_data), 32'h5A);
    check("rm_grant2", 32'(grant_id), 32'd0);
    req_valid = 2'b00;
    step();
    wait_idle("rm");

    // wrap-around on the 3-requester instance (pointer starts at 2)
    step();
    r3_data = 24'hC2B1A0;
    r3_valid = 3'b101;
    #1 check("wr_ready0", 32'(r3_ready), 32'd1);
    step();
    check("wr_start0", 32'(r3_start), 32'd1);
    check("wr_data0", 32'(r3_txd), 32'hA0);
    check("wr_grant0", 32'(r3_gid), 32'd0);
    n = 0;
    step();
    while (!r3_start && n < 30) begin
      step();
      n++;
    end
    check("wr_start1", 32'(r3_start), 32'd1);
`ifdef UART_ARB_PRIORITY_EN
    check("wr_data1", 32'(r3_txd), 32'hA0);
    check("wr_grant1", 32'(r3_gid), 32'd0);
`else
    check("wr_data1", 32'(r3_txd), 32'hC2);
    check("wr_grant1", 32'(r3_gid), 32'd2);
`endif
    r3_valid = 3'b000;
    repeat (8) step();
    check("wr_idle", 32'(r3_abusy), 32'd0);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
